// File: rtl/lut_decoder_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : lut_decoder_scoreboard_if
// Brief    : Expected-entry and DUT-result handshake bundle for the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface lut_decoder_scoreboard_if #(
    parameter int WC    = 16,
    parameter int WD    = 64,
    parameter int LOG2N = 6
);
    logic             exp_valid;
    logic             exp_ready;
    logic [LOG2N-1:0] exp_n;
    logic [WC-1:0]    exp_lut_u_n;
    logic [WC-1:0]    exp_lut_v_n;
    logic [WD-1:0]    exp_lut_X_n;
    logic [WD-1:0]    exp_lut_Y_n;

    logic             res_valid;
    logic [WC-1:0]    res_lut_u_n;
    logic [WC-1:0]    res_lut_v_n;
    logic [WD-1:0]    res_lut_X_n;
    logic [WD-1:0]    res_lut_Y_n;

    modport master (
        output exp_valid, exp_n, exp_lut_u_n, exp_lut_v_n, exp_lut_X_n, exp_lut_Y_n,
        output res_valid, res_lut_u_n, res_lut_v_n, res_lut_X_n, res_lut_Y_n,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_n, exp_lut_u_n, exp_lut_v_n, exp_lut_X_n, exp_lut_Y_n,
        input  res_valid, res_lut_u_n, res_lut_v_n, res_lut_X_n, res_lut_Y_n,
        output exp_ready
    );
endinterface
`default_nettype wire

// File: rtl/lut_decoder_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : lut_decoder_scoreboard
// Brief    : In-order expected/result matcher with per-field tolerance checks,
//            saturating statistics and first-error capture.
// Revision : 1.0 - initial release
// ============================================================================
module lut_decoder_scoreboard #(
    parameter int WC    = 16,
    parameter int WD    = 64,
    parameter int LOG2N = 6,
    parameter int DEPTH = 8,
    parameter int TOL_C = 1,
    parameter int TOL_D = 4,
    parameter int WCNT  = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     enable,
    lut_decoder_scoreboard_if.slave  bus,
    output logic                     cmp_valid,
    output logic [LOG2N-1:0]         cmp_n,
    output logic                     war_u,
    output logic                     war_v,
    output logic                     war_X,
    output logic                     war_Y,
    output logic                     err_u,
    output logic                     err_v,
    output logic                     err_X,
    output logic                     err_Y,
    output logic [WC-1:0]            delta_u,
    output logic [WC-1:0]            delta_v,
    output logic [WD-1:0]            delta_X,
    output logic [WD-1:0]            delta_Y,
    output logic                     orphan,
    output logic [WCNT-1:0]          cmp_cnt,
    output logic [WCNT-1:0]          war_cnt,
    output logic [WCNT-1:0]          err_cnt,
    output logic [WCNT-1:0]          orphan_cnt,
    output logic                     first_err_vld,
    output logic [LOG2N-1:0]         first_err_n,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [WC-1:0]   c_TOL_C   = WC'(TOL_C);
    localparam logic [WD-1:0]   c_TOL_D   = WD'(TOL_D);
    localparam logic [WCNT-1:0] c_CNT_MAX = {WCNT{1'b1}};

    function automatic logic [WC-1:0] f_abs_c(input logic [WC-1:0] a, input logic [WC-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [WD-1:0] f_abs_d(input logic [WD-1:0] a, input logic [WD-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [WCNT-1:0] f_sat(input logic [WCNT-1:0] c);
        return (c == c_CNT_MAX) ? c : c + 1'b1;
    endfunction

    logic [LOG2N-1:0] r_mem_n [DEPTH];
    logic [WC-1:0]    r_mem_u [DEPTH];
    logic [WC-1:0]    r_mem_v [DEPTH];
    logic [WD-1:0]    r_mem_X [DEPTH];
    logic [WD-1:0]    r_mem_Y [DEPTH];

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic             r_cmp_valid;
    logic [LOG2N-1:0] r_cmp_n;
    logic [3:0]       r_war;
    logic [3:0]       r_err;
    logic [WC-1:0]    r_delta_u;
    logic [WC-1:0]    r_delta_v;
    logic [WD-1:0]    r_delta_X;
    logic [WD-1:0]    r_delta_Y;
    logic             r_orphan;
    logic [WCNT-1:0]  r_cmp_cnt;
    logic [WCNT-1:0]  r_war_cnt;
    logic [WCNT-1:0]  r_err_cnt;
    logic [WCNT-1:0]  r_orphan_cnt;
    logic             r_first_err_vld;
    logic [LOG2N-1:0] r_first_err_n;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_orphan_evt;
    logic [WC-1:0]    w_delta_u;
    logic [WC-1:0]    w_delta_v;
    logic [WD-1:0]    w_delta_X;
    logic [WD-1:0]    w_delta_Y;
    logic [3:0]       w_err;
    logic [3:0]       w_war;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // Full blocks the push even when a pop frees a slot this cycle; an empty
    // queue never forwards a same-cycle push to the result side.
    assign w_push       = enable & bus.exp_valid & ~w_full;
    assign w_pop        = enable & bus.res_valid & ~w_empty;
    assign w_orphan_evt = enable & bus.res_valid & w_empty;

    assign w_delta_u = f_abs_c(bus.res_lut_u_n, r_mem_u[r_rd_ptr]);
    assign w_delta_v = f_abs_c(bus.res_lut_v_n, r_mem_v[r_rd_ptr]);
    assign w_delta_X = f_abs_d(bus.res_lut_X_n, r_mem_X[r_rd_ptr]);
    assign w_delta_Y = f_abs_d(bus.res_lut_Y_n, r_mem_Y[r_rd_ptr]);

    assign w_err = {w_delta_u > c_TOL_C, w_delta_v > c_TOL_C,
                    w_delta_X > c_TOL_D, w_delta_Y > c_TOL_D};
    assign w_war = {w_delta_u != '0, w_delta_v != '0,
                    w_delta_X != '0, w_delta_Y != '0} & ~w_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_n[r_wr_ptr] <= bus.exp_n;
            r_mem_u[r_wr_ptr] <= bus.exp_lut_u_n;
            r_mem_v[r_wr_ptr] <= bus.exp_lut_v_n;
            r_mem_X[r_wr_ptr] <= bus.exp_lut_X_n;
            r_mem_Y[r_wr_ptr] <= bus.exp_lut_Y_n;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_cmp_valid     <= 1'b0;
            r_cmp_n         <= '0;
            r_war           <= '0;
            r_err           <= '0;
            r_delta_u       <= '0;
            r_delta_v       <= '0;
            r_delta_X       <= '0;
            r_delta_Y       <= '0;
            r_orphan        <= 1'b0;
            r_cmp_cnt       <= '0;
            r_war_cnt       <= '0;
            r_err_cnt       <= '0;
            r_orphan_cnt    <= '0;
            r_first_err_vld <= 1'b0;
            r_first_err_n   <= '0;
        end else begin
            r_cmp_valid <= 1'b0;
            r_cmp_n     <= '0;
            r_war       <= '0;
            r_err       <= '0;
            r_delta_u   <= '0;
            r_delta_v   <= '0;
            r_delta_X   <= '0;
            r_delta_Y   <= '0;
            r_orphan    <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_cmp_valid <= 1'b1;
                r_cmp_n     <= r_mem_n[r_rd_ptr];
                r_war       <= w_war;
                r_err       <= w_err;
                r_delta_u   <= w_delta_u;
                r_delta_v   <= w_delta_v;
                r_delta_X   <= w_delta_X;
                r_delta_Y   <= w_delta_Y;
                r_cmp_cnt   <= f_sat(r_cmp_cnt);
                // An error on any field takes precedence over warnings.
                if (|w_err) begin
                    r_err_cnt <= f_sat(r_err_cnt);
                    if (!r_first_err_vld) begin
                        r_first_err_vld <= 1'b1;
                        r_first_err_n   <= r_mem_n[r_rd_ptr];
                    end
                end else if (|w_war) begin
                    r_war_cnt <= f_sat(r_war_cnt);
                end
            end

            if (w_orphan_evt) begin
                r_orphan     <= 1'b1;
                r_orphan_cnt <= f_sat(r_orphan_cnt);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.exp_ready = ~w_full;
    assign pending       = r_count;

    assign cmp_valid     = r_cmp_valid;
    assign cmp_n         = r_cmp_n;
    assign {err_u, err_v, err_X, err_Y} = r_err;
    assign {war_u, war_v, war_X, war_Y} = r_war;
    assign delta_u       = r_delta_u;
    assign delta_v       = r_delta_v;
    assign delta_X       = r_delta_X;
    assign delta_Y       = r_delta_Y;
    assign orphan        = r_orphan;
    assign cmp_cnt       = r_cmp_cnt;
    assign war_cnt       = r_war_cnt;
    assign err_cnt       = r_err_cnt;
    assign orphan_cnt    = r_orphan_cnt;
    assign first_err_vld = r_first_err_vld;
    assign first_err_n   = r_first_err_n;

endmodule
`default_nettype wire

// File: tb/tb_lut_decoder_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_decoder_scoreboard
// Brief    : Directed bench for lut_decoder_scoreboard (WCNT=4 for saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_decoder_scoreboard;

    localparam int c_WC = 16, c_WD = 64, c_LOG2N = 6, c_DEPTH = 8, c_WCNT = 4;

    logic clk = 1'b0;
    logic srst;
    logic enable;

    logic               cmp_valid;
    logic [c_LOG2N-1:0] cmp_n;
    logic               war_u, war_v, war_X, war_Y;
    logic               err_u, err_v, err_X, err_Y;
    logic [c_WC-1:0]    delta_u, delta_v;
    logic [c_WD-1:0]    delta_X, delta_Y;
    logic               orphan;
    logic [c_WCNT-1:0]  cmp_cnt, war_cnt, err_cnt, orphan_cnt;
    logic               first_err_vld;
    logic [c_LOG2N-1:0] first_err_n;
    logic [3:0]         pending;

    int n_vec  = 0;
    int n_miss = 0;

    lut_decoder_scoreboard_if #(.WC(c_WC), .WD(c_WD), .LOG2N(c_LOG2N)) bus ();

    lut_decoder_scoreboard #(
        .WC(c_WC), .WD(c_WD), .LOG2N(c_LOG2N), .DEPTH(c_DEPTH),
        .TOL_C(1), .TOL_D(4), .WCNT(c_WCNT)
    ) dut (
        .clk(clk), .srst(srst), .enable(enable), .bus(bus),
        .cmp_valid(cmp_valid), .cmp_n(cmp_n),
        .war_u(war_u), .war_v(war_v), .war_X(war_X), .war_Y(war_Y),
        .err_u(err_u), .err_v(err_v), .err_X(err_X), .err_Y(err_Y),
        .delta_u(delta_u), .delta_v(delta_v), .delta_X(delta_X), .delta_Y(delta_Y),
        .orphan(orphan), .cmp_cnt(cmp_cnt), .war_cnt(war_cnt), .err_cnt(err_cnt),
        .orphan_cnt(orphan_cnt), .first_err_vld(first_err_vld),
        .first_err_n(first_err_n), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk_u(input int n); return 16'h1000 + 16'(n); endfunction
    function automatic logic [15:0] mk_v(input int n); return 16'h2000 + 16'(n); endfunction
    function automatic logic [63:0] mk_X(input int n); return 64'h1111_0000_0000_0000 + 64'(n); endfunction
    function automatic logic [63:0] mk_Y(input int n); return 64'h2222_0000_0000_0000 + 64'(n); endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_raw(input bit v, input int n, input logic [15:0] u, input logic [15:0] vv,
                            input logic [63:0] x, input logic [63:0] y);
        bus.exp_valid   = v;
        bus.exp_n       = 6'(n);
        bus.exp_lut_u_n = u;
        bus.exp_lut_v_n = vv;
        bus.exp_lut_X_n = x;
        bus.exp_lut_Y_n = y;
    endtask

    task automatic push_set(input bit v, input int n);
        push_raw(v, n, mk_u(n), mk_v(n), mk_X(n), mk_Y(n));
    endtask

    task automatic res_raw(input bit v, input logic [15:0] u, input logic [15:0] vv,
                           input logic [63:0] x, input logic [63:0] y);
        bus.res_valid   = v;
        bus.res_lut_u_n = u;
        bus.res_lut_v_n = vv;
        bus.res_lut_X_n = x;
        bus.res_lut_Y_n = y;
    endtask

    task automatic res_exact(input bit v, input int n);
        res_raw(v, mk_u(n), mk_v(n), mk_X(n), mk_Y(n));
    endtask

    // u off by 100: an error on u only
    task automatic res_err(input int n);
        res_raw(1'b1, mk_u(n) + 16'd100, mk_v(n), mk_X(n), mk_Y(n));
    endtask

    function automatic logic [7:0] flags();
        return {err_u, err_v, err_X, err_Y, war_u, war_v, war_X, war_Y};
    endfunction

    task automatic do_reset();
        srst = 1'b1;
        step();
        srst = 1'b0;
    endtask

    initial begin
        srst   = 1'b1;
        enable = 1'b1;
        push_set(1'b0, 0);
        res_exact(1'b0, 0);
        step();
        step();
        chk("rst_pending",   64'(pending), 64'd0);
        chk("rst_ready",     64'(bus.exp_ready), 64'd1);
        chk("rst_cmp_valid", 64'(cmp_valid), 64'd0);
        chk("rst_cmp_cnt",   64'(cmp_cnt), 64'd0);
        chk("rst_first_err", 64'(first_err_vld), 64'd0);
        srst = 1'b0;

        // exact-match compares
        for (int i = 1; i <= 3; i++) begin
            push_set(1'b1, i);
            step();
        end
        push_set(1'b0, 0);
        chk("t1_pending", 64'(pending), 64'd3);
        for (int i = 1; i <= 3; i++) begin
            res_exact(1'b1, i);
            step();
            chk("t1_cmp_valid", 64'(cmp_valid), 64'd1);
            chk("t1_cmp_n",     64'(cmp_n), 64'(i));
            chk("t1_flags",     64'(flags()), 64'd0);
            chk("t1_delta_u",   64'(delta_u), 64'd0);
        end
        res_exact(1'b0, 0);
        step();
        chk("t1_cmp_idle", 64'(cmp_valid), 64'd0);
        chk("t1_cmp_cnt",  64'(cmp_cnt), 64'd3);
        chk("t1_err_cnt",  64'(err_cnt), 64'd0);
        chk("t1_pending0", 64'(pending), 64'd0);

        // tolerance boundaries
        push_raw(1'b1, 5, 16'h0100, 16'hFFFF, 64'h100, 64'h200);
        step();
        push_set(1'b0, 0);
        res_raw(1'b1, 16'h0101, 16'h0000, 64'h0FB, 64'h204);
        step();
        res_exact(1'b0, 0);
        chk("t2_cmp_valid", 64'(cmp_valid), 64'd1);
        chk("t2_flags",     64'(flags()), 64'b0110_1001);
        chk("t2_delta_u",   64'(delta_u), 64'd1);
        chk("t2_delta_v",   64'(delta_v), 64'hFFFF);
        chk("t2_delta_X",   delta_X, 64'd5);
        chk("t2_delta_Y",   delta_Y, 64'd4);
        chk("t2_cmp_cnt",   64'(cmp_cnt), 64'd4);
        chk("t2_err_cnt",   64'(err_cnt), 64'd1);
        chk("t2_war_cnt",   64'(war_cnt), 64'd0);
        chk("t2_ferr_vld",  64'(first_err_vld), 64'd1);
        chk("t2_ferr_n",    64'(first_err_n), 64'd5);
        push_set(1'b1, 6);
        step();
        push_set(1'b0, 0);
        res_raw(1'b1, mk_u(6) + 16'd1, mk_v(6), mk_X(6), mk_Y(6));
        step();
        res_exact(1'b0, 0);
        chk("t2w_flags",   64'(flags()), 64'b0000_1000);
        chk("t2w_war_cnt", 64'(war_cnt), 64'd1);
        chk("t2w_err_cnt", 64'(err_cnt), 64'd1);
        chk("t2w_ferr_n",  64'(first_err_n), 64'd5);

        // full queue, refused push, streaming through pointer wrap
        do_reset();
        for (int n = 0; n < 8; n++) begin
            push_set(1'b1, n);
            step();
        end
        chk("t3_full_ready", 64'(bus.exp_ready), 64'd0);
        chk("t3_full_pend",  64'(pending), 64'd8);
        push_set(1'b1, 8);
        res_exact(1'b1, 0);
        step();
        chk("t3_pp_cmp_n", 64'(cmp_n), 64'd0);
        chk("t3_pp_pend",  64'(pending), 64'd7);
        chk("t3_pp_ready", 64'(bus.exp_ready), 64'd1);
        for (int k = 0; k < 20; k++) begin
            push_set(1'b1, 8 + k);
            res_exact(1'b1, 1 + k);
            step();
            chk("t3_st_cmp_n", 64'(cmp_n), 64'(1 + k));
            chk("t3_st_flags", 64'(flags()), 64'd0);
            chk("t3_st_pend",  64'(pending), 64'd7);
        end
        push_set(1'b0, 0);
        for (int k = 0; k < 7; k++) begin
            res_exact(1'b1, 21 + k);
            step();
            chk("t3_dr_cmp_n", 64'(cmp_n), 64'(21 + k));
            chk("t3_dr_flags", 64'(flags()), 64'd0);
        end
        res_exact(1'b0, 0);
        chk("t3_pend0", 64'(pending), 64'd0);

        // orphan with a same-cycle push
        do_reset();
        push_set(1'b1, 9);
        res_exact(1'b1, 9);
        step();
        chk("t4_orphan",     64'(orphan), 64'd1);
        chk("t4_cmp_valid",  64'(cmp_valid), 64'd0);
        chk("t4_orphan_cnt", 64'(orphan_cnt), 64'd1);
        chk("t4_pending",    64'(pending), 64'd1);
        push_set(1'b0, 0);
        step();
        res_exact(1'b0, 0);
        chk("t4_cmp_valid2", 64'(cmp_valid), 64'd1);
        chk("t4_cmp_n",      64'(cmp_n), 64'd9);
        chk("t4_orphan2",    64'(orphan), 64'd0);
        chk("t4_flags",      64'(flags()), 64'd0);

        // counter saturation at 2^4-1
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            push_set(i < 20, 10 + i);
            if (i > 0) res_err(10 + i - 1);
            else       res_exact(1'b0, 0);
            step();
        end
        push_set(1'b0, 0);
        res_exact(1'b0, 0);
        chk("t5_err_cnt",  64'(err_cnt), 64'd15);
        chk("t5_cmp_cnt",  64'(cmp_cnt), 64'd15);
        chk("t5_war_cnt",  64'(war_cnt), 64'd0);
        chk("t5_ferr_vld", 64'(first_err_vld), 64'd1);
        chk("t5_ferr_n",   64'(first_err_n), 64'd10);

        // reset mid-operation
        do_reset();
        for (int n = 20; n < 25; n++) begin
            push_set(1'b1, n);
            step();
        end
        push_set(1'b0, 0);
        res_err(20);
        step();
        chk("t6_cmp_valid", 64'(cmp_valid), 64'd1);
        chk("t6_pending",   64'(pending), 64'd4);
        chk("t6_err_cnt",   64'(err_cnt), 64'd1);
        srst = 1'b1;
        res_err(21);
        step();
        srst = 1'b0;
        res_exact(1'b0, 0);
        chk("t6r_cmp_valid", 64'(cmp_valid), 64'd0);
        chk("t6r_pending",   64'(pending), 64'd0);
        chk("t6r_cmp_cnt",   64'(cmp_cnt), 64'd0);
        chk("t6r_err_cnt",   64'(err_cnt), 64'd0);
        chk("t6r_ferr_vld",  64'(first_err_vld), 64'd0);
        chk("t6r_ready",     64'(bus.exp_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lut_decoder_scoreboard.md
# lut_decoder_scoreboard

Self-checking scoreboard for the BKM FPU LUT decoder, the sequential successor to the combinational LUT-decoder checker. It queues expected LUT entries (u_n, v_n, X_n, Y_n, tagged with iteration index n) from the reference model and matches them in order against DUT results arriving later. It compares every matched pair with per-field tolerance and keeps saturating statistics plus first-error capture. It sits in the lut_decoder verification environment between the reference model and the DUT outputs.

## Interface
- WC, 16, width of u/v LUT entries
- WD, 64, width of X/Y LUT entries
- LOG2N, 6, width of iteration index n
- DEPTH, 8, expected-queue depth; power of 2, ≥2
- TOL_C, 1, max |delta| on u/v counted as warning rather than error
- TOL_D, 4, max |delta| on X/Y counted as warning rather than error
- WCNT, 16, statistics counter width
- clk  in  1  clock; all logic on rising edge
- srst  in  1  reset, synchronous, active-high
- enable  in  1  global qualifier; when low, no push, pop, compare or count
- exp_valid  in  1  expected entry present
- exp_ready  out  1  queue can accept (= !full)
- exp_n  in  LOG2N  iteration tag of expected entry
- exp_lut_u_n, exp_lut_v_n  in  WC  expected u/v
- exp_lut_X_n, exp_lut_Y_n  in  WD  expected X/Y
- res_valid  in  1  DUT result present (no back-pressure)
- res_lut_u_n, res_lut_v_n  in  WC  DUT u/v
- res_lut_X_n, res_lut_Y_n  in  WD  DUT X/Y
- cmp_valid  out  1  compare outputs valid this cycle
- cmp_n  out  LOG2N  tag of compared entry
- war_u, war_v, war_X, war_Y  out  1  0 < delta ≤ tolerance
- err_u, err_v, err_X, err_Y  out  1  delta > tolerance
- delta_u, delta_v  out  WC  |res − exp|
- delta_X, delta_Y  out  WD  |res − exp|
- orphan  out  1  result arrived with queue empty (1-cycle pulse)
- cmp_cnt, war_cnt, err_cnt, orphan_cnt  out  WCNT  saturating counters
- first_err_vld  out  1  sticky; an error has been captured
- first_err_n  out  LOG2N  tag of first erroneous compare
- pending  out  log2(DEPTH)+1  entries currently queued

## Operation
- Queue: circular buffer, DEPTH entries, separate rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
- Push: enable & exp_valid & exp_ready. Pop: enable & res_valid & (pending≠0).
- Simultaneous push and pop: both happen; pending unchanged. When full, exp_ready=0 even if a pop occurs the same cycle (no write-through).
- When empty, a same-cycle push is not visible to a same-cycle result (no bypass). The result is an orphan: orphan pulses, orphan_cnt increments, and no compare occurs.
- Compare: on pop, the head entry is compared with the res_* fields. Deltas are unsigned absolute differences at full field width, computed as (a≥b)?a−b:b−a, with no sign interpretation.
- Per field: delta=0 → both flags 0; 0<delta≤TOL → war=1; delta>TOL → err=1. war and err are never both 1.
- Counters, one increment per compare: cmp_cnt always; err_cnt if any err_*; war_cnt if any war_* and no err_*. Each counter saturates at 2^WCNT−1.
- First error: on the first compare with any err_*, first_err_n ← tag and first_err_vld ← 1. Both hold until srst.
- enable low: state frozen; cmp_valid and orphan are 0.

## Timing
- Compare latency 1: a pop at edge t drives cmp_valid, cmp_n, flags and deltas at t+1. They are valid for exactly one cycle, then cmp_valid=0. Flags and deltas are forced to 0 when cmp_valid=0.
- Counters and first_err_* update on the same edge as cmp_valid.
- exp_ready and pending reflect registered state (combinational from the count only).
- Reset values: everything 0; exp_ready=1 (after reset, queue empty).
- srst mid-operation flushes the queue, discards the in-flight compare (cmp_valid=0 next cycle) and clears the counters and first-error capture. srst has priority over enable.
- Throughput: one push and one compare per cycle sustained.

## Test plan
- Reset, then push 3 entries (n=1,2,3); pending=3. Results exactly equal → three cmp_valid pulses at pop+1, all flags 0, cmp_cnt=3, err_cnt=0.
- Tolerance boundary (TOL_C=1, TOL_D=4): res_u=exp_u+1 → war_u=1, delta_u=1. res_X=exp_X−5 → err_X=1, delta_X=5. res_v=0, exp_v=2^WC−1 → err_v, delta_v=2^WC−1. first_err_n equals the tag; war_cnt unchanged because err dominates.
- Fill DEPTH=8 → exp_ready=0. Push+pop in the same cycle → pop accepted, push refused, pending=7. Continue 20 entries through pointer wrap with no loss or reorder (cmp_n sequence matches).
- res_valid with empty queue while exp_valid is high → orphan=1, orphan_cnt=1, no cmp_valid. The entry is queued, pending=1.
- WCNT=4, 20 compares each with errors → err_cnt holds at 15 with no wrap. first_err_n stays at the first tag.
- srst asserted the cycle after a pop with pending=4 → next cycle cmp_valid=0, pending=0, counters 0, first_err_vld=0, exp_ready=1.
